// File: rtl/mr_round_scheduler_if.sv
// Handshake and operand bundle between the Miller-Rabin round scheduler,
// its candidate/witness sources, the shared modexp engine and the verdict sink.
interface mr_round_scheduler_if #(
  parameter int unsigned BIT_LENGTH = 128
);
  // candidate stream
  logic                  p_valid;
  logic                  p_ready;
  logic [BIT_LENGTH-1:0] p_value;
  // witness-base stream
  logic                  w_valid;
  logic                  w_ready;
  logic [BIT_LENGTH-1:0] w_value;
  // modular-exponentiation engine request / response
  logic                  exp_req_valid;
  logic                  exp_req_ready;
  logic [BIT_LENGTH-1:0] exp_base;
  logic [BIT_LENGTH-1:0] exp_power;
  logic [BIT_LENGTH-1:0] exp_mod;
  logic                  exp_rsp_valid;
  logic [BIT_LENGTH-1:0] exp_rsp_value;
  // verdict and status
  logic                  res_valid;
  logic                  res_prime;
  logic                  busy;

  // environment side: sources, engine and sink
  modport master (
    output p_valid, p_value,
    output w_valid, w_value,
    output exp_req_ready, exp_rsp_valid, exp_rsp_value,
    input  p_ready, w_ready,
    input  exp_req_valid, exp_base, exp_power, exp_mod,
    input  res_valid, res_prime, busy
  );

  // scheduler side
  modport slave (
    input  p_valid, p_value,
    input  w_valid, w_value,
    input  exp_req_ready, exp_rsp_valid, exp_rsp_value,
    output p_ready, w_ready,
    output exp_req_valid, exp_base, exp_power, exp_mod,
    output res_valid, res_prime, busy
  );
endinterface

// File: rtl/mr_round_scheduler.sv
// Miller-Rabin round scheduler: decomposes p-1 = m * 2^r, pulls witness bases,
// drives a shared modexp engine (one outstanding request) and emits a verdict.
module mr_round_scheduler #(
  parameter int unsigned BIT_LENGTH = 128,
  parameter int unsigned NUM_ROUNDS = 8
) (
  input logic                aclk,
  input logic                areset,
  mr_round_scheduler_if.slave bus
);

  localparam int unsigned RW = $clog2(BIT_LENGTH) + 1;
  localparam int unsigned NW = $clog2(NUM_ROUNDS + 1);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_DECOMP   = 4'd1;
  localparam logic [3:0] S_GET_W    = 4'd2;
  localparam logic [3:0] S_EXP_REQ  = 4'd3;
  localparam logic [3:0] S_EXP_WAIT = 4'd4;
  localparam logic [3:0] S_CHECK    = 4'd5;
  localparam logic [3:0] S_SQ_REQ   = 4'd6;
  localparam logic [3:0] S_SQ_WAIT  = 4'd7;
  localparam logic [3:0] S_SQ_CHECK = 4'd8;
  localparam logic [3:0] S_DONE     = 4'd9;

  localparam logic [BIT_LENGTH-1:0] ONE = BIT_LENGTH'(1);
  localparam logic [BIT_LENGTH-1:0] TWO = BIT_LENGTH'(2);
  localparam logic [BIT_LENGTH-1:0] THR = BIT_LENGTH'(3);

  logic [3:0]            state_q, state_d;
  logic [BIT_LENGTH-1:0] p_q, p_d;
  logic [BIT_LENGTH-1:0] m_q, m_d;
  logic [BIT_LENGTH-1:0] a_q, a_d;
  logic [BIT_LENGTH-1:0] x_q, x_d;
  logic [RW-1:0]         r_q, r_d;
  logic [RW-1:0]         j_q, j_d;
  logic [NW-1:0]         round_q, round_d;
  logic                  verdict_q, verdict_d;

  logic [BIT_LENGTH-1:0] p_minus1;
  logic [BIT_LENGTH-1:0] p_minus2;
  logic [RW-1:0]         j_inc;
  logic [NW-1:0]         round_inc;
  logic                  round_pass;

  // Derived values used by the witness range check and the x tests
  always_comb begin
    p_minus1  = p_q - ONE;
    p_minus2  = p_q - TWO;
    j_inc     = j_q + RW'(1);
    round_inc = round_q + NW'(1);
  end

  // Next-state and datapath update; a passed round is resolved once after the case
  always_comb begin
    state_d    = state_q;
    p_d        = p_q;
    m_d        = m_q;
    a_d        = a_q;
    x_d        = x_q;
    r_d        = r_q;
    j_d        = j_q;
    round_d    = round_q;
    verdict_d  = verdict_q;
    round_pass = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.p_valid) begin
          p_d = bus.p_value;
          if (bus.p_value < TWO) begin
            verdict_d = 1'b0;
            state_d   = S_DONE;
          end else if (bus.p_value == TWO || bus.p_value == THR) begin
            verdict_d = 1'b1;
            state_d   = S_DONE;
          end else if (!bus.p_value[0]) begin
            verdict_d = 1'b0;
            state_d   = S_DONE;
          end else begin
            m_d       = bus.p_value - ONE;
            r_d       = '0;
            j_d       = '0;
            round_d   = '0;
            verdict_d = 1'b0;
            state_d   = S_DECOMP;
          end
        end
      end

      S_DECOMP: begin
        if (!m_q[0]) begin
          m_d = m_q >> 1;
          r_d = r_q + RW'(1);
        end else begin
          state_d = S_GET_W;
        end
      end

      S_GET_W: begin
        if (bus.w_valid) begin
          if (bus.w_value >= TWO && bus.w_value <= p_minus2) begin
            a_d     = bus.w_value;
            state_d = S_EXP_REQ;
          end else begin
            round_pass = 1'b1;
          end
        end
      end

      S_EXP_REQ: begin
        if (bus.exp_req_ready) state_d = S_EXP_WAIT;
      end

      S_EXP_WAIT: begin
        if (bus.exp_rsp_valid) begin
          x_d     = bus.exp_rsp_value;
          state_d = S_CHECK;
        end
      end

      S_CHECK: begin
        if (x_q == ONE || x_q == p_minus1) begin
          round_pass = 1'b1;
        end else if (r_q == RW'(1)) begin
          verdict_d = 1'b0;
          state_d   = S_DONE;
        end else begin
          j_d     = RW'(1);
          state_d = S_SQ_REQ;
        end
      end

      S_SQ_REQ: begin
        if (bus.exp_req_ready) state_d = S_SQ_WAIT;
      end

      S_SQ_WAIT: begin
        if (bus.exp_rsp_valid) begin
          x_d     = bus.exp_rsp_value;
          state_d = S_SQ_CHECK;
        end
      end

      S_SQ_CHECK: begin
        if (x_q == p_minus1) begin
          round_pass = 1'b1;
        end else if (x_q == ONE) begin
          verdict_d = 1'b0;
          state_d   = S_DONE;
        end else if (j_inc == r_q) begin
          verdict_d = 1'b0;
          state_d   = S_DONE;
        end else begin
          j_d     = j_inc;
          state_d = S_SQ_REQ;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (round_pass) begin
      round_d = round_inc;
      if (round_inc == NW'(NUM_ROUNDS)) begin
        verdict_d = 1'b1;
        state_d   = S_DONE;
      end else begin
        state_d = S_GET_W;
      end
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q   <= S_IDLE;
      p_q       <= '0;
      m_q       <= '0;
      a_q       <= '0;
      x_q       <= '0;
      r_q       <= '0;
      j_q       <= '0;
      round_q   <= '0;
      verdict_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      p_q       <= p_d;
      m_q       <= m_d;
      a_q       <= a_d;
      x_q       <= x_d;
      r_q       <= r_d;
      j_q       <= j_d;
      round_q   <= round_d;
      verdict_q <= verdict_d;
    end
  end

  // Handshake and payload outputs decoded from state; payload comes only from
  // registers, so it stays stable while a request waits for acceptance
  always_comb begin
    bus.p_ready       = (state_q == S_IDLE);
    bus.w_ready       = (state_q == S_GET_W);
    bus.exp_req_valid = (state_q == S_EXP_REQ) || (state_q == S_SQ_REQ);
    bus.exp_base      = (state_q == S_SQ_REQ) ? x_q : a_q;
    bus.exp_power     = (state_q == S_SQ_REQ) ? TWO : m_q;
    bus.exp_mod       = p_q;
    bus.res_valid     = (state_q == S_DONE);
    bus.res_prime     = (state_q == S_DONE) && verdict_q;
    bus.busy          = (state_q != S_IDLE);
  end

endmodule
